// File: rtl/bsg_mem_1rw_sync_mask_write_bit_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : bsg_mem_1rw_sync_mask_write_bit_arb_if
// Purpose  : Two-client request/response bus into the SRAM arbiter.
// Revision : 1.0
// ============================================================================
interface bsg_mem_1rw_sync_mask_write_bit_arb_if #(
  parameter int width_p      = 8,
  parameter int addr_width_p = 4
);
  logic [1:0]              v_i;
  logic [1:0]              w_i;
  logic [2*addr_width_p-1:0] addr_i;
  logic [2*width_p-1:0]    data_i;
  logic [2*width_p-1:0]    w_mask_i;
  logic [1:0]              yumi_o;
  logic [1:0]              r_v_o;
  logic [width_p-1:0]      data_o;

  modport slave (
    input  v_i, w_i, addr_i, data_i, w_mask_i,
    output yumi_o, r_v_o, data_o
  );

  modport master (
    output v_i, w_i, addr_i, data_i, w_mask_i,
    input  yumi_o, r_v_o, data_o
  );
endinterface
`default_nettype wire

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_arb.sv
`default_nettype none
// ============================================================================
// Module   : bsg_mem_1rw_sync_mask_write_bit_arb
// Purpose  : Zero-sweep initializer and 2-port round-robin arbiter for one
//            1RW bit-masked synchronous SRAM.
// Revision : 1.0
// ============================================================================
module bsg_mem_1rw_sync_mask_write_bit_arb #(
  parameter int width_p       = -1,
  parameter int els_p         = -1,
  parameter int addr_width_lp = (els_p == 1) ? 1 : $clog2(els_p),
  parameter logic [width_p-1:0] init_val_p = '0
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  bsg_mem_1rw_sync_mask_write_bit_arb_if.slave cl_if,
  output logic                     init_done_o,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [width_p-1:0]       mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i
);

  localparam logic [0:0] c_st_init = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;
  localparam logic [addr_width_lp-1:0] c_last_addr = addr_width_lp'(els_p - 1);
  localparam logic [31:0] c_els = els_p;

  logic [0:0]               r_state;
  logic [addr_width_lp-1:0] r_init_cnt;
  logic                     r_rr;
  logic                     r_rd_v;
  logic                     r_rd_id;

  logic                     w_run;
  logic                     w_win;
  logic                     w_grant;
  logic [1:0]               w_yumi;
  logic [addr_width_lp-1:0] w_addr_sel;
  logic [width_p-1:0]       w_data_sel;
  logic [width_p-1:0]       w_mask_sel;

  assign w_run   = (r_state == c_st_run);
  // Only on contention does the pointer decide; a lone requester always wins.
  assign w_win   = (&cl_if.v_i) ? r_rr : cl_if.v_i[1];
  assign w_grant = w_run & (|cl_if.v_i);

  assign w_addr_sel = w_win ? cl_if.addr_i[2*addr_width_lp-1:addr_width_lp]
                            : cl_if.addr_i[addr_width_lp-1:0];
  assign w_data_sel = w_win ? cl_if.data_i[2*width_p-1:width_p]
                            : cl_if.data_i[width_p-1:0];
  assign w_mask_sel = w_win ? cl_if.w_mask_i[2*width_p-1:width_p]
                            : cl_if.w_mask_i[width_p-1:0];

  assign w_yumi       = w_grant ? (w_win ? 2'b10 : 2'b01) : 2'b00;
  assign cl_if.yumi_o = w_yumi;
  assign cl_if.r_v_o  = {r_rd_v & r_rd_id, r_rd_v & ~r_rd_id};
  assign cl_if.data_o = mem_data_i;
  assign init_done_o  = w_run;

  always_comb begin
    mem_v_o      = 1'b0;
    mem_w_o      = 1'b0;
    mem_addr_o   = w_addr_sel;
    mem_data_o   = w_data_sel;
    mem_w_mask_o = w_mask_sel;
    // State is already INIT while reset is held, so gate the sweep enable here.
    if (reset_n_i) begin
      if (!w_run) begin
        mem_v_o      = 1'b1;
        mem_w_o      = 1'b1;
        mem_addr_o   = r_init_cnt;
        mem_data_o   = init_val_p;
        mem_w_mask_o = '1;
      end else begin
        mem_v_o = |cl_if.v_i;
        mem_w_o = (|cl_if.v_i) & cl_if.w_i[w_win];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state    <= c_st_init;
      r_init_cnt <= '0;
      r_rr       <= 1'b0;
      r_rd_v     <= 1'b0;
      r_rd_id    <= 1'b0;
    end else begin
      if (!w_run) begin
        if (r_init_cnt == c_last_addr) r_state    <= c_st_run;
        else                           r_init_cnt <= r_init_cnt + 1'b1;
      end
      if (w_grant) r_rr <= ~w_win;
      r_rd_v  <= w_grant & ~cl_if.w_i[w_win];
      r_rd_id <= w_win;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      if (w_grant) assert (32'(w_addr_sel) < c_els);
      assert ($onehot0(w_yumi));
      assert (w_run || (w_yumi == 2'b00));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_mem_1rw_sync_mask_write_bit_arb
// Purpose  : Directed vector bench for the SRAM arbiter/initializer.
// Revision : 1.0
// ============================================================================
module tb_bsg_mem_1rw_sync_mask_write_bit_arb;

  localparam int W = 64, E = 15, AW = 4;
  localparam int W2 = 8, E2 = 124, AW2 = 7;
  localparam logic [63:0] F = 64'hFFFF, L = 64'h00FF, O = '1, Z = '0, D = 64'h1234;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bsg_mem_1rw_sync_mask_write_bit_arb_if #(.width_p(W),  .addr_width_p(AW))  if1 ();
  bsg_mem_1rw_sync_mask_write_bit_arb_if #(.width_p(W2), .addr_width_p(AW2)) if2 ();

  logic          done1, mv1, mw1;
  logic [AW-1:0] ma1;
  logic [W-1:0]  md1, mm1, mr1;
  logic           done2, mv2, mw2;
  logic [AW2-1:0] ma2;
  logic [W2-1:0]  md2, mm2;

  bsg_mem_1rw_sync_mask_write_bit_arb #(.width_p(W), .els_p(E)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .cl_if(if1), .init_done_o(done1),
    .mem_v_o(mv1), .mem_w_o(mw1), .mem_addr_o(ma1), .mem_data_o(md1),
    .mem_w_mask_o(mm1), .mem_data_i(mr1)
  );

  bsg_mem_1rw_sync_mask_write_bit_arb #(.width_p(W2), .els_p(E2)) dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .cl_if(if2), .init_done_o(done2),
    .mem_v_o(mv2), .mem_w_o(mw2), .mem_addr_o(ma2), .mem_data_o(md2),
    .mem_w_mask_o(mm2), .mem_data_i('0)
  );

  // SRAM model for the 15-word instance
  logic [W-1:0] mem [0:15];
  always @(posedge clk) begin
    if (mv1) begin
      if (mw1) mem[ma1] <= (mem[ma1] & ~mm1) | (md1 & mm1);
      else     mr1 <= mem[ma1];
    end
  end

  // Sweep monitor for the 124-word instance
  int cnt2 = 0;
  int max2 = 0;
  always @(negedge clk) begin
    #4;
    if (!reset_n) cnt2 = 0;
    else if (mv2 && !done2) begin
      cnt2++;
      if (int'(ma2) > max2) max2 = int'(ma2);
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  v, w;
    logic [3:0]  a0, a1;
    logic [63:0] d0, d1, m0, m1;
    logic [1:0]  ey;
    logic        ev, ew;
    logic [3:0]  ea;
    logic [63:0] em;
    logic [1:0]  er;
    logic [63:0] ed;
  } vec_t;

  function automatic vec_t mk(logic [1:0] v, logic [1:0] w, logic [3:0] a0, logic [3:0] a1,
                              logic [63:0] d0, logic [63:0] d1, logic [63:0] m0, logic [63:0] m1,
                              logic [1:0] ey, logic ev, logic ew, logic [3:0] ea,
                              logic [63:0] em, logic [1:0] er, logic [63:0] ed);
    vec_t r;
    r.v = v; r.w = w; r.a0 = a0; r.a1 = a1; r.d0 = d0; r.d1 = d1; r.m0 = m0; r.m1 = m1;
    r.ey = ey; r.ev = ev; r.ew = ew; r.ea = ea; r.em = em; r.er = er; r.ed = ed;
    return r;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [3:0] a0,
                       input logic [3:0] a1, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [63:0] m0, input logic [63:0] m1);
    if1.v_i = v; if1.w_i = w; if1.addr_i = {a1, a0};
    if1.data_i = {d1, d0}; if1.w_mask_i = {m1, m0};
  endtask

  vec_t vt [14];
  logic [1:0] cy_yumi [4];
  logic [1:0] cy_rv   [5];

  initial begin
    vt[0]  = mk(2'b01, 2'b01, 3, 0, F, Z, L, Z,  2'b01, 1, 1, 3, L, 2'b00, Z);
    vt[1]  = mk(2'b01, 2'b00, 3, 0, Z, Z, L, Z,  2'b01, 1, 0, 3, L, 2'b00, Z);
    vt[2]  = mk(2'b00, 2'b00, 0, 0, Z, Z, Z, Z,  2'b00, 0, 0, 0, Z, 2'b01, L);
    vt[3]  = mk(2'b10, 2'b00, 0, 3, Z, Z, Z, Z,  2'b10, 1, 0, 3, Z, 2'b00, Z);
    for (int i = 4; i < 8; i++)
      vt[i] = mk(2'b10, 2'b00, 0, 3, Z, Z, Z, Z, 2'b10, 1, 0, 3, Z, 2'b10, L);
    vt[8]  = mk(2'b11, 2'b00, 5, 3, Z, Z, Z, Z,  2'b01, 1, 0, 5, Z, 2'b10, L);
    vt[9]  = mk(2'b10, 2'b00, 0, 3, Z, Z, Z, Z,  2'b10, 1, 0, 3, Z, 2'b01, Z);
    vt[10] = mk(2'b10, 2'b10, 0, 7, Z, D, Z, O,  2'b10, 1, 1, 7, O, 2'b10, L);
    vt[11] = mk(2'b01, 2'b01, 7, 0, F, Z, Z, Z,  2'b01, 1, 1, 7, Z, 2'b00, Z);
    vt[12] = mk(2'b10, 2'b00, 0, 7, Z, Z, Z, Z,  2'b10, 1, 0, 7, Z, 2'b00, Z);
    vt[13] = mk(2'b00, 2'b00, 0, 0, Z, Z, Z, Z,  2'b00, 0, 0, 0, Z, 2'b10, D);
    cy_yumi = '{2'b01, 2'b10, 2'b01, 2'b10};
    cy_rv   = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};

    if2.v_i = '0; if2.w_i = '0; if2.addr_i = '0; if2.data_i = '0; if2.w_mask_i = '0;
    reset_n = 1'b0;
    drive(2'b11, 2'b00, 0, 0, Z, Z, Z, Z);

    // Reset state with requests already asserted
    repeat (2) @(negedge clk);
    #1;
    chk("reset yumi", 64'(if1.yumi_o), 64'(2'b00));
    chk("reset r_v", 64'(if1.r_v_o), 64'(2'b00));
    chk("reset init_done", 64'(done1), 64'(1'b0));
    chk("reset mem_v", 64'(mv1), 64'(1'b0));

    // Init sweep: 15 full-mask zero writes, v_i=11 ignored
    for (int i = 0; i < E; i++) begin
      @(negedge clk);
      if (i == 0) reset_n = 1'b1;
      #1;
      chk($sformatf("sweep%0d mem_v", i), 64'(mv1), 64'(1'b1));
      chk($sformatf("sweep%0d mem_w", i), 64'(mw1), 64'(1'b1));
      chk($sformatf("sweep%0d addr", i), 64'(ma1), 64'(i));
      chk($sformatf("sweep%0d mask", i), 64'(mm1), O);
      chk($sformatf("sweep%0d data", i), 64'(md1), Z);
      chk($sformatf("sweep%0d yumi", i), 64'(if1.yumi_o), 64'(2'b00));
      chk($sformatf("sweep%0d init_done", i), 64'(done1), 64'(1'b0));
    end

    // Contention on addr 0 right after init
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) drive(2'b00, 2'b00, 0, 0, Z, Z, Z, Z);
      #1;
      if (i == 0) chk("init_done rise", 64'(done1), 64'(1'b1));
      chk($sformatf("cont%0d yumi", i), 64'(if1.yumi_o), (i < 4) ? 64'(cy_yumi[i]) : 64'(2'b00));
      chk($sformatf("cont%0d r_v", i), 64'(if1.r_v_o), 64'(cy_rv[i]));
      if (i > 0) chk($sformatf("cont%0d data", i), 64'(if1.data_o), Z);
    end

    // Vector table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vt[i].v, vt[i].w, vt[i].a0, vt[i].a1, vt[i].d0, vt[i].d1, vt[i].m0, vt[i].m1);
      #1;
      chk($sformatf("row%0d yumi", i), 64'(if1.yumi_o), 64'(vt[i].ey));
      chk($sformatf("row%0d mem_v", i), 64'(mv1), 64'(vt[i].ev));
      if (vt[i].ev) begin
        chk($sformatf("row%0d mem_w", i), 64'(mw1), 64'(vt[i].ew));
        chk($sformatf("row%0d addr", i), 64'(ma1), 64'(vt[i].ea));
        chk($sformatf("row%0d mask", i), 64'(mm1), vt[i].em);
      end
      chk($sformatf("row%0d r_v", i), 64'(if1.r_v_o), 64'(vt[i].er));
      if (vt[i].er != 2'b00) chk($sformatf("row%0d data", i), 64'(if1.data_o), vt[i].ed);
    end

    // Reset during sweep address 7
    @(negedge clk); reset_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) reset_n = 1'b1;
      #1;
      chk($sformatf("resweep%0d addr", i), 64'(ma1), 64'(i));
    end
    #1 reset_n = 1'b0;
    #1;
    chk("midsweep rst mem_v", 64'(mv1), 64'(1'b0));
    chk("midsweep rst yumi", 64'(if1.yumi_o), 64'(2'b00));
    chk("midsweep rst init_done", 64'(done1), 64'(1'b0));
    @(negedge clk); reset_n = 1'b1;
    #1;
    chk("restart mem_v", 64'(mv1), 64'(1'b1));
    chk("restart addr", 64'(ma1), 64'(0));
    repeat (E) @(negedge clk);
    #1;
    chk("reinit done", 64'(done1), 64'(1'b1));

    // Reset the cycle after a read grant
    @(negedge clk);
    drive(2'b01, 2'b00, 3, 0, Z, Z, Z, Z);
    #1;
    chk("pre-rst read yumi", 64'(if1.yumi_o), 64'(2'b01));
    @(negedge clk);
    reset_n = 1'b0;
    drive(2'b00, 2'b00, 0, 0, Z, Z, Z, Z);
    #1;
    chk("rst after read r_v", 64'(if1.r_v_o), 64'(2'b00));
    chk("rst after read mem_v", 64'(mv1), 64'(1'b0));
    @(negedge clk); reset_n = 1'b1;
    #1;
    chk("post-rst r_v", 64'(if1.r_v_o), 64'(2'b00));
    chk("post-rst addr", 64'(ma1), 64'(0));

    // Non-power-of-two depth: counter must stop at 123
    repeat (130) @(negedge clk);
    #6;
    chk("els124 init_done", 64'(done2), 64'(1'b1));
    chk("els124 max addr", 64'(max2), 64'(E2 - 1));
    chk("els124 sweep len", 64'(cnt2), 64'(E2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bsg_mem_1rw_sync_mask_write_bit_arb.md
Name: bsg_mem_1rw_sync_mask_write_bit_arb

Overview:
Two-requester round-robin arbiter and post-reset initializer for one single-port, bit-masked synchronous SRAM instance (one access per cycle, read data one cycle after access). After reset, it sweeps the whole array to zero with a full mask. It then grants one requester per cycle and routes read data back with a per-port valid pulse. It sits between the memory instance and two clients, for example a cache fill engine and a coherence/snoop engine.

Parameters:
width_p, -1 (must be set), data and mask width in bits
els_p, -1 (must be set), number of words
addr_width_lp, BSG_SAFE_CLOG2(els_p), address width (derived, do not override)
init_val_p, 0, value written to every word during the init sweep (replicated width_p bits)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
v_i  in  2  per-port request valid
w_i  in  2  per-port write (1) / read (0)
addr_i  in  2*addr_width_lp  per-port address; port p in slice [p*aw +: aw]
data_i  in  2*width_p  per-port write data
w_mask_i  in  2*width_p  per-port bit write mask (1 = write the bit)
yumi_o  out  2  request accepted this cycle (at most one bit set)
r_v_o  out  2  read data valid for port p this cycle
data_o  out  width_p  read data, shared by both ports, qualified by r_v_o
init_done_o  out  1  init sweep complete
mem_v_o  out  1  memory access enable
mem_w_o  out  1  memory write enable
mem_addr_o  out  addr_width_lp  memory address
mem_data_o  out  width_p  memory write data
mem_w_mask_o  out  width_p  memory bit mask
mem_data_i  in  width_p  memory read data (valid the cycle after a read access)

Behaviour:
- Asynchronous reset (reset_n_i=0):
  - All state clears immediately: state=INIT, init counter=0, rr pointer=0 (port 0 has priority), pending-read register=none.
  - Outputs during reset: yumi_o=0, r_v_o=0, init_done_o=0, mem_v_o=0.
  - Reset asserted mid-sweep or mid-read discards the pending read (no r_v_o pulse) and restarts the sweep from address 0.
- FSM states: INIT, RUN.
- INIT state:
  - Every cycle: mem_v_o=1, mem_w_o=1, mem_addr_o=counter, mem_data_o=init_val_p, mem_w_mask_o=all ones. yumi_o=0.
  - Counter increments each cycle. When counter==els_p-1, the write still issues and the next state is RUN. This holds for non-power-of-two els_p: the counter never exceeds els_p-1.
  - The sweep takes exactly els_p cycles. init_done_o rises the first cycle in RUN and stays 1 until reset.
- RUN state, arbitration (combinational within the cycle):
  - If only one v_i bit is set, that port wins.
  - If both are set, the port indicated by the rr pointer wins.
  - yumi_o[winner]=1. The memory is driven from the winner's fields, and mem_v_o=|v_i.
  - The rr pointer moves to the non-winner after every grant.
  - Without a grant, the pointer holds.
- Handshake:
  - v_i may depend on nothing from this block.
  - yumi_o depends combinationally on v_i.
  - A client must hold its request stable until yumi_o, and may drop or change it the cycle after.
- Read return:
  - On a granted read, the port id is registered.
  - The next cycle: r_v_o[id]=1 and data_o=mem_data_i.
  - Granted writes produce no r_v_o.
  - Back-to-back reads from alternating ports produce one r_v_o pulse per cycle.
- Write mask is passed through unchanged. A mask of all zeros is still a granted access (mem_v_o=1) that leaves memory unchanged.
- data_o when r_v_o=0 is don't-care: passes mem_data_i through.
- Simulation-only checks:
  - Assert that a granted addr_i is < els_p.
  - Assert that yumi_o is never two-hot.
  - Assert that v_i is ignored in INIT: no yumi_o until init_done_o.
- Throughput: one access per cycle, no bubbles between grants. Read latency from grant to r_v_o is 1 cycle.

Test Plan:
- Init sweep, els_p=15, width_p=64: release reset → mem_w_o=1 for exactly 15 cycles, addresses 0..14 with full mask; init_done_o=1 on cycle 16. v_i=2'b11 held throughout gets no yumi_o until then.
- Masked write then read, port 0: write addr 3, data 0xFFFF, mask 0x00FF; then read addr 3 → r_v_o=2'b01 one cycle after the read grant, data_o=0x00FF.
- Contention: v_i=2'b11 held for 4 cycles after init → yumi_o sequence 01,10,01,10. Both ports reading addr 0 produce r_v_o 01,10,01,10, delayed by one cycle.
- Single requester: port 1 only, 5 consecutive requests → yumi_o=2'b10 every cycle. Then a simultaneous request grants port 0 first (pointer moved to 0 after the port-1 grants).
- Reset mid-operation: assert reset_n_i low during sweep address 7, and again the cycle after a read grant → outputs zero immediately, no r_v_o pulse, sweep restarts at 0.
- Non-power-of-two depth, els_p=124: counter stops at 123. A mem_addr_o of 124..127 never appears during INIT.
